// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_ctrl
// Description : Instruction fetch controller. It owns the fetch PC, drives
//               the instruction memory, and buffers the returned words in a
//               small prefetch FIFO. Words are handed to decode, tagged with
//               their PCs, over a valid/ready handshake. A branch redirect
//               flushes the FIFO. Optional halt detection is enabled with the
//               IFETCH_HALT_DETECT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_ctrl #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    parameter int                FIFO_DEPTH  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [DATA_W-1:0] HALT_OPCODE = '1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_read,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted
);

    localparam int               c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int               c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

`ifdef IFETCH_HALT_DETECT_EN
    localparam logic c_HALT_EN = 1'b1;
`else
    localparam logic c_HALT_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_halted;
    logic [ADDR_W-1:0]    r_fetch_pc;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   w_count_nxt;
    logic [DATA_W-1:0]    r_fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0]    r_fifo_pc   [FIFO_DEPTH];

    logic                 w_pop;
    logic                 w_push;
    logic                 w_halt_hit;

    assign instr_valid = (r_count != '0);
    assign w_pop       = instr_valid & instr_ready;
    // A full FIFO may still fetch when its head leaves in the same cycle.
    assign imem_read   = ~rst & (r_state == FETCH) & ((r_count < c_DEPTH) | w_pop);
    // The word read during a redirect belongs to the old path and is dropped.
    assign w_push      = imem_read & ~redirect_valid;
    assign w_halt_hit  = c_HALT_EN & w_push & (imem_rdata == HALT_OPCODE);

    assign imem_addr   = r_fetch_pc;
    assign instr_data  = instr_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign instr_pc    = instr_valid ? r_fifo_pc[r_rd_ptr]   : '0;
    assign halted      = r_halted;

    // Occupancy after this edge: a redirect flushes, otherwise push/pop net out.
    always_comb begin
        w_count_nxt = r_count;
        if (redirect_valid) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Next state: redirect always resumes fetching; a pushed halt word stops it.
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = FETCH;
        end else if (w_halt_hit) begin
            w_state_nxt = HALT;
        end
    end

    // State register; halted rises once the halt word has drained out of the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= FETCH;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_halted <= ~redirect_valid & (w_state_nxt == HALT) & (w_count_nxt == '0);
        end
    end

    // Fetch PC and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr   <= r_wr_ptr + 1'b1;
                    r_fetch_pc <= r_fetch_pc + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
        end
    end

    // FIFO storage; contents are qualified by the count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= imem_rdata;
            r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_ctrl
// Description : Self-checking bench for ifetch_ctrl: directed vector table,
//               hand-written reset/halt sequences and a randomized run
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_ctrl;

    localparam int c_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] imem_addr;
    logic        imem_read;
    logic [15:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr_data;
    logic [15:0] instr_pc;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    logic        halt_override = 1'b0;
    logic [15:0] halt_addr = '0;

    ifetch_ctrl #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .FIFO_DEPTH  (c_DEPTH),
        .RESET_PC    (16'h0000),
        .HALT_OPCODE (16'hFFFF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_read      (imem_read),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory: word i holds 16'h1000 + i.
    always_comb begin
        imem_rdata = 16'h1000 + imem_addr;
        if (halt_override && imem_addr == halt_addr) imem_rdata = 16'hFFFF;
    end

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then settle.
    task automatic drive(input logic rdy, input logic rv, input logic [15:0] rpc);
        @(negedge clk);
        rst            = 1'b0;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst            = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_addr",   imem_addr,   16'h0000);
        chk("rst_read",   imem_read,   1'b0);
        chk("rst_valid",  instr_valid, 1'b0);
        chk("rst_data",   instr_data,  16'h0000);
        chk("rst_pc",     instr_pc,    16'h0000);
        chk("rst_halted", halted,      1'b0);
    endtask

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [15:0] rpc;
        logic        e_valid;
        logic [15:0] e_pc;
        logic [15:0] e_data;
        logic        e_read;
        logic [15:0] e_addr;
    } vec_t;

    vec_t vecs[15];

    logic [15:0] q[$];
    logic [15:0] m_fpc;

    initial begin
        // stream, backpressure (FIFO fills, fetch stops), redirects incl. wrap
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h1000, 1'b1, 16'h0001};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h1001, 1'b1, 16'h0002};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h1002, 1'b1, 16'h0003};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h1002, 1'b0, 16'h0004};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h1002, 1'b0, 16'h0004};
        vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h1002, 1'b1, 16'h0004};
        vecs[7]  = '{1'b0, 1'b1, 16'h0040, 1'b1, 16'h0003, 16'h1003, 1'b0, 16'h0005};
        vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0040};
        vecs[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0040, 16'h1040, 1'b1, 16'h0041};
        vecs[10] = '{1'b1, 1'b1, 16'hFFFE, 1'b1, 16'h0041, 16'h1041, 1'b1, 16'h0042};
        vecs[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFE};
        vecs[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hFFFE, 16'h0FFE, 1'b1, 16'hFFFF};
        vecs[13] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'h0FFF, 1'b1, 16'h0000};
        vecs[14] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h1000, 1'b1, 16'h0001};

        reset_dut();
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
            chk("vec_valid", instr_valid, vecs[i].e_valid);
            chk("vec_pc",    instr_pc,    vecs[i].e_pc);
            chk("vec_data",  instr_data,  vecs[i].e_data);
            chk("vec_read",  imem_read,   vecs[i].e_read);
            chk("vec_addr",  imem_addr,   vecs[i].e_addr);
            chk("vec_halt",  halted,      1'b0);
        end

        // mid-stream reset pulse
        drive(1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        drive(1'b1, 1'b0, 16'h0000);
        chk("mrst_valid", instr_valid, 1'b0);
        chk("mrst_pc",    instr_pc,    16'h0000);
        chk("mrst_data",  instr_data,  16'h0000);
        chk("mrst_addr",  imem_addr,   16'h0000);
        chk("mrst_read",  imem_read,   1'b1);
        chk("mrst_halt",  halted,      1'b0);
        drive(1'b1, 1'b0, 16'h0000);
        chk("mrst_first_valid", instr_valid, 1'b1);
        chk("mrst_first_pc",    instr_pc,    16'h0000);
        chk("mrst_first_data",  instr_data,  16'h1000);

        // halt opcode at word 5
        halt_override = 1'b1;
        halt_addr     = 16'h0005;
        reset_dut();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, 16'h0000);
            chk("halt_fetch_read", imem_read, 1'b1);
            chk("halt_fetch_addr", imem_addr, 16'(k));
            if (k > 0) chk("halt_fetch_pc", instr_pc, 16'(k - 1));
        end
        drive(1'b1, 1'b0, 16'h0000);
        chk("halt_word_valid", instr_valid, 1'b1);
        chk("halt_word_pc",    instr_pc,    16'h0005);
        chk("halt_word_data",  instr_data,  16'hFFFF);
`ifdef IFETCH_HALT_DETECT_EN
        chk("halt_no_fetch", imem_read, 1'b0);
        drive(1'b1, 1'b0, 16'h0000);
        chk("halt_set",      halted,      1'b1);
        chk("halt_empty",    instr_valid, 1'b0);
        chk("halt_read_off", imem_read,   1'b0);
        chk("halt_addr",     imem_addr,   16'h0006);
        drive(1'b1, 1'b1, 16'h0000);
        chk("halt_hold", halted, 1'b1);
        drive(1'b1, 1'b0, 16'h0000);
        chk("halt_clear",   halted,    1'b0);
        chk("halt_restart", imem_read, 1'b1);
        chk("halt_raddr",   imem_addr, 16'h0000);
`else
        chk("nohalt_fetch", imem_read, 1'b1);
        chk("nohalt_addr",  imem_addr, 16'h0006);
        drive(1'b1, 1'b0, 16'h0000);
        chk("nohalt_flag",  halted,     1'b0);
        chk("nohalt_pc6",   instr_pc,   16'h0006);
        chk("nohalt_data6", instr_data, 16'h1006);
`endif
        halt_override = 1'b0;

        // randomized run against a queue model of the fetch stream
        reset_dut();
        q.delete();
        m_fpc = 16'h0000;
        for (int n = 0; n < 1500; n++) begin
            logic        rdy;
            logic        rv;
            logic [15:0] rpc;
            logic        e_valid;
            logic        e_pop;
            logic        e_read;
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 16'h0FFF))
                                              : 16'($urandom_range(16'hFFF0, 16'hFFFF));
            drive(rdy, rv, rpc);
            e_valid = (q.size() > 0);
            e_pop   = e_valid && rdy;
            e_read  = (q.size() < c_DEPTH) || e_pop;
            chk("rnd_valid", instr_valid, e_valid);
            chk("rnd_pc",    instr_pc,    e_valid ? q[0] : 16'h0000);
            chk("rnd_data",  instr_data,  e_valid ? mem_word(q[0]) : 16'h0000);
            chk("rnd_read",  imem_read,   e_read);
            chk("rnd_addr",  imem_addr,   m_fpc);
            chk("rnd_halt",  halted,      1'b0);
            if (rv) begin
                q.delete();
                m_fpc = rpc;
            end else begin
                if (e_pop) void'(q.pop_front());
                if (e_read) begin
                    q.push_back(m_fpc);
                    m_fpc = m_fpc + 16'h0001;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
